// File: rtl/core_muldiv.sv
// core_muldiv -- multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).
//
// Runs a 32-iteration shift-add multiply or restoring divide per accepted
// start and reports completion with a one-cycle o_done pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   i_start   request, sampled only in IDLE
//   i_flush   kill any in-flight operation (wins over i_start)
//   i_funct3  RV32M opcode selector
//   i_num1u   rs1 value
//   i_num2u   rs2 value
//   i_rd      destination register tag
//   o_busy    high whenever the sequencer is not IDLE
//   o_done    one-cycle result-valid pulse
//   o_res     result, held until the next completion
//   o_rd      tag of the completed op, held like o_res
//
// Optional feature macro: CORE_MULDIV_FASTMUL_EN
//   When defined, all multiplies complete in one cycle through a 33x33
//   signed product; division is unchanged. Results are identical either way.

module core_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_num1u,
    input  logic [31:0] i_num2u,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_res,
    output logic [4:0]  o_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [2:0]  op_r;
    logic [4:0]  rd_r;
    logic [31:0] mcand_r;   // multiplicand magnitude, or divisor magnitude
    logic [63:0] acc_r;     // {high/remainder, multiplier/quotient}
    logic        neg_r;     // sign to apply to the selected result

    logic        is_div_s;
    logic        sa_s;
    logic        sb_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        special_s;
    logic [31:0] special_res_s;
    logic        neg_start_s;
    logic        fast_en_s;
    logic [31:0] fast_res_s;
    logic [63:0] step_s;
    logic [31:0] fin_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Decode the request presented in IDLE: signedness, magnitudes, special cases.
    always_comb begin
        is_div_s = i_funct3[2];
        case (i_funct3)
            3'b001:  begin sa_s = 1'b1; sb_s = 1'b1; end
            3'b010:  begin sa_s = 1'b1; sb_s = 1'b0; end
            3'b100:  begin sa_s = 1'b1; sb_s = 1'b1; end
            3'b110:  begin sa_s = 1'b1; sb_s = 1'b1; end
            default: begin sa_s = 1'b0; sb_s = 1'b0; end
        endcase
        a_neg_s = sa_s & i_num1u[31];
        b_neg_s = sb_s & i_num2u[31];
        a_mag_s = mag32(i_num1u, a_neg_s);
        b_mag_s = mag32(i_num2u, b_neg_s);
        // Remainders follow the dividend's sign; everything else the XOR of signs.
        if (is_div_s && i_funct3[1]) begin
            neg_start_s = a_neg_s;
        end else begin
            neg_start_s = a_neg_s ^ b_neg_s;
        end
        if (is_div_s && (i_num2u == 32'd0)) begin
            special_s     = 1'b1;
            special_res_s = i_funct3[1] ? i_num1u : 32'hFFFF_FFFF;
        end else if (is_div_s && !i_funct3[0] &&
                     (i_num1u == 32'h8000_0000) && (i_num2u == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_res_s = i_funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_res_s = 32'd0;
        end
    end

`ifdef CORE_MULDIV_FASTMUL_EN
    logic signed [32:0] fa_s;
    logic signed [32:0] fb_s;
    logic signed [63:0] fprod_s;

    // Single-cycle signed product; the low 64 bits of the 66-bit result suffice.
    always_comb begin
        fa_s       = {sa_s & i_num1u[31], i_num1u};
        fb_s       = {sb_s & i_num2u[31], i_num2u};
        fprod_s    = 64'(fa_s) * 64'(fb_s);
        fast_en_s  = 1'b1;
        if (i_funct3[1:0] == 2'b00) begin
            fast_res_s = fprod_s[31:0];
        end else begin
            fast_res_s = fprod_s[63:32];
        end
    end
`else
    // Fast multiply disabled: multiplies take the iterative path.
    always_comb begin
        fast_en_s  = 1'b0;
        fast_res_s = 32'd0;
    end
`endif

    logic [32:0] sum_s;
    logic [32:0] rem33_s;
    logic [31:0] diff_s;
    logic [63:0] full_s;
    logic [31:0] raw_s;

    // One iteration of the datapath plus sign correction of the final value.
    always_comb begin
        // Multiply: add multiplicand to the high half when the multiplier LSB is set, shift right.
        sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mcand_r} : 33'd0);
        // Divide: shift the next dividend bit into the 33-bit partial remainder.
        rem33_s = {acc_r[63:32], acc_r[31]};
        diff_s  = rem33_s[31:0] - mcand_r;
        if (!op_r[2]) begin
            step_s = {sum_s, acc_r[31:1]};
        end else if (rem33_s >= {1'b0, mcand_r}) begin
            step_s = {diff_s, acc_r[30:0], 1'b1};
        end else begin
            step_s = {rem33_s[31:0], acc_r[30:0], 1'b0};
        end
        full_s = neg_r ? (64'd0 - step_s) : step_s;
        raw_s  = op_r[1] ? step_s[63:32] : step_s[31:0];
        if (!op_r[2]) begin
            fin_s = (op_r[1:0] == 2'b00) ? full_s[31:0] : full_s[63:32];
        end else begin
            fin_s = mag32(raw_s, neg_r);
        end
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
            op_r    <= 3'd0;
            rd_r    <= 5'd0;
            mcand_r <= 32'd0;
            acc_r   <= 64'd0;
            neg_r   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_res   <= 32'd0;
            o_rd    <= 5'd0;
        end else if (i_flush) begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        op_r    <= i_funct3;
                        rd_r    <= i_rd;
                        cnt_r   <= 6'd0;
                        neg_r   <= neg_start_s;
                        mcand_r <= is_div_s ? b_mag_s : a_mag_s;
                        acc_r   <= {32'd0, (is_div_s ? a_mag_s : b_mag_s)};
                        o_busy  <= 1'b1;
                        if (special_s) begin
                            state_r <= DONE;
                            o_done  <= 1'b1;
                            o_res   <= special_res_s;
                            o_rd    <= i_rd;
                        end else if (fast_en_s && !is_div_s) begin
                            state_r <= DONE;
                            o_done  <= 1'b1;
                            o_res   <= fast_res_s;
                            o_rd    <= i_rd;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= DONE;
                        o_done  <= 1'b1;
                        o_res   <= fin_s;
                        o_rd    <= rd_r;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
